parallel_pole_fir: RTL and testbench

PARALLEL_POLE_FIR -- requirements
Module: parallel_pole_fir

---
 rtl/parallel_pole_fir.sv | 117 +++++++++++
 tb/tb_parallel_pole_fir.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_pole_fir.sv
// Polyphase FIR: NSAMP samples per clock, NOUT output phases of NTAP taps each,
// double-buffered coefficients and a registered adder tree of fixed latency.
module parallel_pole_fir #(
   parameter int NBITS = 16,
   parameter int NFRAC = 2,
   parameter int NSAMP = 8,
   parameter int NTAP  = 8,
   parameter int NOUT  = 2,
   localparam int ADRW = (NOUT * NTAP > 1) ? $clog2(NOUT * NTAP) : 1,
   localparam int LAT  = 2 + $clog2(NTAP)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NBITS*NSAMP-1:0] dat_i,
   input  logic                   dat_valid_i,
   input  logic [ADRW-1:0]        coeff_adr_i,
   input  logic                   coeff_wr_i,
   input  logic [17:0]            coeff_dat_i,
   input  logic                   coeff_update_i,
   output logic [48*NOUT-1:0]     y_out,
   output logic                   y_valid_o
);

   localparam int NCOEF = NOUT * NTAP;
   localparam int LVL   = LAT - 2;
   localparam int NLEAF = 1 << LVL;
   localparam int HBLK  = (NTAP - 1 + NSAMP - 1) / NSAMP;
   localparam int HLEN  = (HBLK > 0) ? HBLK * NSAMP : NSAMP;
   localparam int WLEN  = HLEN + NSAMP;
   localparam logic [ADRW:0] NCOEF_W = (ADRW + 1)'(NCOEF);

   typedef logic signed [NBITS-1:0] samp_t;
   typedef logic signed [17:0]      coef_t;
   typedef logic signed [47:0]      acc_t;

   if (NFRAC < 0 || NFRAC >= NBITS || NSAMP < 2 || NSAMP > 16 ||
       NTAP < 1 || NTAP > 16 || NOUT < 1 || NOUT > NSAMP) begin : g_bad_param
      $error("parallel_pole_fir: parameter out of range");
   end

   coef_t shadow [NCOEF];
   coef_t active [NCOEF];
   samp_t hist   [HLEN];
   samp_t win    [WLEN];
   acc_t  prod   [NOUT][NLEAF];
   acc_t  tree   [NOUT][LVL+1][NLEAF];
   logic [LVL:0] vld;

   // Sample window: older history first, then the current block; x[NSAMP*n+m] sits at win[HLEN+m].
   // NOTE: every element is assigned on every pass, so no latch can be inferred.
   always_comb begin
      for (int i = 0; i < HLEN; i++) win[i] = hist[i];
      for (int i = 0; i < NSAMP; i++) win[HLEN + i] = samp_t'(dat_i[i*NBITS +: NBITS]);
   end

   // Products are formed against the active bank in the accept cycle, so one block never mixes sets.
   for (genvar c = 0; c < NOUT; c++) begin : g_chain
      for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
         if (j < NTAP) begin : g_tap
            assign prod[c][j] = acc_t'(win[HLEN + c - j]) * acc_t'(active[c*NTAP + j]);
         end else begin : g_pad
            assign prod[c][j] = '0;
         end
      end
   end

   // NOTE: both coefficient banks are reset because an all-zero filter is the defined post-reset state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCOEF; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignment lets a same-cycle update copy the pre-write shadow contents.
         if (coeff_update_i) active <= shadow;
         if (coeff_wr_i && ({1'b0, coeff_adr_i} < NCOEF_W)) shadow[coeff_adr_i] <= coef_t'(coeff_dat_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HLEN; i++) hist[i] <= '0;
      end else if (dat_valid_i) begin
         for (int i = 0; i < HLEN; i++) hist[i] <= win[i + NSAMP];
      end
   end

   // Tree level 0 holds products; each further level halves the live entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NOUT; c++)
            for (int l = 0; l <= LVL; l++)
               for (int j = 0; j < NLEAF; j++) tree[c][l][j] <= '0;
         vld       <= '0;
         y_out     <= '0;
         y_valid_o <= 1'b0;
      end else begin
         for (int c = 0; c < NOUT; c++) begin
            for (int j = 0; j < NLEAF; j++) tree[c][0][j] <= prod[c][j];
            for (int l = 1; l <= LVL; l++) begin
               for (int j = 0; j < (NLEAF >> l); j++)
                  tree[c][l][j] <= tree[c][l-1][2*j] + tree[c][l-1][2*j+1];
               for (int j = (NLEAF >> l); j < NLEAF; j++)
                  tree[c][l][j] <= '0;
            end
         end
         vld[0] <= dat_valid_i;
         for (int l = 1; l <= LVL; l++) vld[l] <= vld[l-1];
         y_valid_o <= vld[LVL];
         if (vld[LVL]) begin
            for (int c = 0; c < NOUT; c++) y_out[48*c +: 48] <= tree[c][LVL][0];
         end
      end
   end

endmodule

// File: tb/tb_parallel_pole_fir.sv
// Randomized bench for parallel_pole_fir against a sample-level reference model
// that keeps the whole accepted stream and evaluates the convolution directly.
module tb_parallel_pole_fir;

   localparam int NBITS = 16;
   localparam int NSAMP = 8;
   localparam int NTAP  = 8;
   localparam int NOUT  = 2;
   localparam int NCOEF = NOUT * NTAP;
   localparam int ADRW  = 4;
   localparam int LAT   = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NBITS*NSAMP-1:0] dat_i;
   logic                   dat_valid_i;
   logic [ADRW-1:0]        coeff_adr_i;
   logic                   coeff_wr_i;
   logic [17:0]            coeff_dat_i;
   logic                   coeff_update_i;
   logic [48*NOUT-1:0]     y_out;
   logic                   y_valid_o;

   // Second instance with 15 coefficients, so an out-of-range address fits the 4-bit port.
   logic [NBITS*NSAMP-1:0] b_dat;
   logic                   b_valid;
   logic [3:0]             b_adr;
   logic                   b_wr;
   logic [17:0]            b_cdat;
   logic                   b_upd;
   logic [48*3-1:0]        b_y;
   logic                   b_yv;

   always #5 clk = ~clk;

   parallel_pole_fir #(.NBITS(16), .NFRAC(2), .NSAMP(8), .NTAP(8), .NOUT(2)) dut (
      .clk(clk), .rst(rst), .dat_i(dat_i), .dat_valid_i(dat_valid_i),
      .coeff_adr_i(coeff_adr_i), .coeff_wr_i(coeff_wr_i), .coeff_dat_i(coeff_dat_i),
      .coeff_update_i(coeff_update_i), .y_out(y_out), .y_valid_o(y_valid_o)
   );

   parallel_pole_fir #(.NBITS(16), .NFRAC(2), .NSAMP(8), .NTAP(5), .NOUT(3)) dut_small (
      .clk(clk), .rst(rst), .dat_i(b_dat), .dat_valid_i(b_valid),
      .coeff_adr_i(b_adr), .coeff_wr_i(b_wr), .coeff_dat_i(b_cdat),
      .coeff_update_i(b_upd), .y_out(b_y), .y_valid_o(b_yv)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      int     due;
      longint y0;
      longint y1;
   } exp_t;

   int     m_shadow [NCOEF];
   int     m_active [NCOEF];
   int     hx [$];
   exp_t   pend [$];
   longint last_y [NOUT];
   int     lane [NSAMP];
   int     cyc = 0;

   function automatic int rand_s16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   function automatic int rand_s18();
      logic signed [17:0] v;
      v = 18'($urandom);
      return int'(v);
   endfunction

   // y_c[n] = sum_t h_c[t] * x[NSAMP*n + c - t], samples before the first accepted block are 0.
   function automatic longint ref_y(input int c);
      int     nb;
      int     idx;
      longint s;
      nb = hx.size() / NSAMP - 1;
      s  = 0;
      for (int t = 0; t < NTAP; t++) begin
         idx = NSAMP * nb + c - t;
         if (idx >= 0) s += longint'(m_active[c*NTAP + t]) * longint'(hx[idx]);
      end
      return s;
   endfunction

   function automatic longint chain(input int c);
      logic signed [47:0] v;
      v = y_out[48*c +: 48];
      return longint'(v);
   endfunction

   // One clock: update the model with what the DUT samples at this edge, then compare outputs.
   // A block accepted at cycle k is due at cycle k+LAT; cyc counts edges, so due = cyc + LAT.
   task automatic step();
      exp_t e;
      for (int i = 0; i < NSAMP; i++) dat_i[i*NBITS +: NBITS] = NBITS'(lane[i]);
      if (dat_valid_i) begin
         for (int i = 0; i < NSAMP; i++) hx.push_back(lane[i]);
         e.due = cyc + LAT;
         e.y0  = ref_y(0);
         e.y1  = ref_y(1);
         pend.push_back(e);
      end
      if (coeff_update_i) m_active = m_shadow;
      if (coeff_wr_i && int'(coeff_adr_i) < NCOEF) m_shadow[coeff_adr_i] = int'($signed(coeff_dat_i));
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         check("y_valid_due", longint'(y_valid_o), 1);
         check("y_chain0", chain(0), pend[0].y0);
         check("y_chain1", chain(1), pend[0].y1);
         last_y[0] = pend[0].y0;
         last_y[1] = pend[0].y1;
         void'(pend.pop_front());
      end else begin
         check("y_valid_idle", longint'(y_valid_o), 0);
         check("y_hold0", chain(0), last_y[0]);
         check("y_hold1", chain(1), last_y[1]);
      end
   endtask

   task automatic send_rand(input bit v);
      dat_valid_i = v;
      for (int i = 0; i < NSAMP; i++) lane[i] = rand_s16();
      step();
   endtask

   task automatic send_const(input int val);
      dat_valid_i = 1'b1;
      for (int i = 0; i < NSAMP; i++) lane[i] = val;
      step();
   endtask

   task automatic idle(input int n);
      repeat (n) send_rand(1'b0);
   endtask

   task automatic wr_coeff(input int adr, input int val);
      coeff_wr_i  = 1'b1;
      coeff_adr_i = ADRW'(adr);
      coeff_dat_i = 18'(val);
      send_rand(1'b0);
      coeff_wr_i  = 1'b0;
   endtask

   task automatic update();
      coeff_update_i = 1'b1;
      send_rand(1'b0);
      coeff_update_i = 1'b0;
   endtask

   task automatic do_reset();
      dat_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_async_valid", longint'(y_valid_o), 0);
      check("rst_async_y0", chain(0), 0);
      check("rst_async_y1", chain(1), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      for (int i = 0; i < NCOEF; i++) begin
         m_shadow[i] = 0;
         m_active[i] = 0;
      end
      hx.delete();
      pend.delete();
      last_y[0] = 0;
      last_y[1] = 0;
   endtask

   initial begin
      rst = 1'b1;
      dat_i = '0;
      dat_valid_i = 1'b0;
      coeff_adr_i = '0;
      coeff_wr_i = 1'b0;
      coeff_dat_i = '0;
      coeff_update_i = 1'b0;
      b_dat = '0;
      b_valid = 1'b0;
      b_adr = '0;
      b_wr = 1'b0;
      b_cdat = '0;
      b_upd = 1'b0;
      for (int i = 0; i < NSAMP; i++) lane[i] = 0;
      for (int i = 0; i < NCOEF; i++) begin
         m_shadow[i] = 0;
         m_active[i] = 0;
      end
      last_y[0] = 0;
      last_y[1] = 0;

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_valid", longint'(y_valid_o), 0);
      check("reset_y0", chain(0), 0);
      check("reset_y1", chain(1), 0);
      rst = 1'b0;

      // Impulse: h_0 = {1.0, 0.5, 0, 0, 0, 0, 0, -1.0}, h_1[1] = 0.5
      wr_coeff(0, 16384);
      wr_coeff(1, 8192);
      wr_coeff(7, -16384);
      wr_coeff(9, 8192);
      update();
      for (int i = 0; i < NSAMP; i++) lane[i] = 0;
      lane[0] = 4;
      dat_valid_i = 1'b1;
      step();
      idle(LAT + 1);
      check("impulse_y0", chain(0), 65536);
      check("impulse_y1", chain(1), 32768);
      repeat (3) send_const(0);
      idle(LAT + 1);

      // Continuous random blocks with random coefficients
      for (int a = 0; a < NCOEF; a++) wr_coeff(a, rand_s18());
      update();
      repeat (40) send_rand(1'b1);
      idle(LAT + 1);

      // Gapped stream 1,0,0,1
      repeat (6) begin
         send_rand(1'b1);
         send_rand(1'b0);
         send_rand(1'b0);
         send_rand(1'b1);
      end
      idle(LAT + 1);

      // Mid-stream update with a simultaneous write at address 3; writes never stall the stream
      for (int a = 0; a < NCOEF; a++) begin
         coeff_wr_i  = 1'b1;
         coeff_adr_i = ADRW'(a);
         coeff_dat_i = 18'(rand_s18());
         send_rand(1'b1);
      end
      coeff_adr_i    = 4'd3;
      coeff_dat_i    = 18'(rand_s18());
      coeff_update_i = 1'b1;
      send_rand(1'b1);
      coeff_wr_i     = 1'b0;
      coeff_update_i = 1'b0;
      repeat (10) send_rand(1'b1);
      coeff_update_i = 1'b1;
      send_rand(1'b1);
      coeff_update_i = 1'b0;
      repeat (8) send_rand(1'b1);
      idle(LAT + 1);

      // Reset with three blocks in flight: nothing emerges, coefficients read as zero
      repeat (3) send_rand(1'b1);
      do_reset();
      idle(LAT + 1);
      repeat (4) send_rand(1'b1);
      idle(LAT + 1);
      check("post_reset_y0", chain(0), 0);
      check("post_reset_y1", chain(1), 0);

      // Extremes: every product is 2^32 and eight of them sum exactly
      for (int a = 0; a < NCOEF; a++) wr_coeff(a, -131072);
      update();
      send_const(-32768);
      send_const(-32768);
      idle(LAT + 1);
      check("extreme_y0", chain(0), 64'sd34359738368);
      check("extreme_y1", chain(1), 64'sd34359738368);

      // Out-of-range coefficient write on the 15-entry instance
      b_wr = 1'b1;
      b_adr = 4'd0;  b_cdat = 18'd16384;  send_rand(1'b0);
      b_adr = 4'd14; b_cdat = 18'd16384;  send_rand(1'b0);
      b_adr = 4'd15; b_cdat = 18'h3ffff;  send_rand(1'b0);
      b_wr = 1'b0;
      b_upd = 1'b1;
      send_rand(1'b0);
      b_upd = 1'b0;
      for (int i = 0; i < NSAMP; i++) b_dat[i*NBITS +: NBITS] = 16'd4;
      b_valid = 1'b1;
      send_rand(1'b0);
      send_rand(1'b0);
      b_valid = 1'b0;
      idle(LAT + 1);
      check("small_y0", longint'($signed(b_y[0 +: 48])), 65536);
      check("small_y1", longint'($signed(b_y[48 +: 48])), 0);
      check("small_y2", longint'($signed(b_y[96 +: 48])), 65536);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
